instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 56 +++++
 rtl/instr_sequencer_decode.sv | 29 ++
 rtl/instr_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode constants,
// FSM state encoding, instruction classes and datapath select encodings.
package instr_sequencer_pkg;

    // Opcode map from the datapath instruction register
    localparam logic [3:0] OP_LD       = 4'b0000;
    localparam logic [3:0] OP_ST       = 4'b0001;
    localparam logic [3:0] OP_RTYPE_LO = 4'b0010;
    localparam logic [3:0] OP_RTYPE_HI = 4'b1001;
    localparam logic [3:0] OP_BEQ      = 4'b1011;
    localparam logic [3:0] OP_BNE      = 4'b1100;
    localparam logic [3:0] OP_JMP      = 4'b1101;

    // FSM state encoding, visible on the state output
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CLS_LD      = 3'd0,
        CLS_ST      = 3'd1,
        CLS_RTYPE   = 3'd2,
        CLS_BEQ     = 3'd3,
        CLS_BNE     = 3'd4,
        CLS_JMP     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_e;

    // PC source select
    localparam logic [1:0] PC_SRC_PLUS2  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU operation select
    localparam logic [1:0] ALU_OP_RTYPE = 2'b00;
    localparam logic [1:0] ALU_OP_CMP   = 2'b01;
    localparam logic [1:0] ALU_OP_ADDR  = 2'b10;

    // True for the contiguous R-type opcode range
    function automatic logic is_rtype_opcode(input logic [3:0] op);
        return (op >= OP_RTYPE_LO) && (op <= OP_RTYPE_HI);
    endfunction

    // Conditional-branch resolution from class and ALU zero result
    function automatic logic branch_taken(input op_class_e cls, input logic zero_flag);
        return ((cls == CLS_BEQ) && zero_flag) || ((cls == CLS_BNE) && !zero_flag);
    endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Opcode-to-class decoder for the instruction sequencer.
// Unlisted opcodes (1010, 1110, 1111) map to CLS_ILLEGAL.
module instr_sequencer_decode
    import instr_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_e  op_class
);

    // Classify the current instruction-register opcode
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_LD:   op_class = CLS_LD;
            OP_ST:   op_class = CLS_ST;
            OP_BEQ:  op_class = CLS_BEQ;
            OP_BNE:  op_class = CLS_BNE;
            OP_JMP:  op_class = CLS_JMP;
            default: begin
                if (is_rtype_opcode(opcode)) begin
                    op_class = CLS_RTYPE;
                end else begin
                    op_class = CLS_ILLEGAL;
                end
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM
// with a retired-instruction counter.
// Build option: define ILLEGAL_OP_TRAP_EN to send illegal opcodes to a
// sticky TRAP state; otherwise they execute as a counted NOP.
// Outputs are combinational from state and inputs, forced to zero in reset.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             zero_flag,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap
);

    state_e           state_r;
    state_e           next_state_s;
    state_e           retire_next_s;
    op_class_e        op_class_s;
    logic             retire_s;
    logic [CNT_W-1:0] count_r;

    logic             mem_req_s;
    logic             mem_we_s;
    logic             ir_write_s;
    logic             pc_write_s;
    logic [1:0]       pc_src_s;
    logic             reg_write_s;
    logic             reg_dst_s;
    logic             alu_src_s;
    logic             mem_to_reg_s;
    logic [1:0]       alu_op_s;
    logic             trap_s;

    instr_sequencer_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class_s)
    );

    // State register with synchronous reset to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Next-state and raw control decode
    always_comb begin
        next_state_s  = state_r;
        retire_next_s = run ? ST_FETCH : ST_IDLE;
        retire_s      = 1'b0;
        mem_req_s     = 1'b0;
        mem_we_s      = 1'b0;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        pc_src_s      = PC_SRC_PLUS2;
        reg_write_s   = 1'b0;
        reg_dst_s     = 1'b0;
        alu_src_s     = 1'b0;
        mem_to_reg_s  = 1'b0;
        alu_op_s      = ALU_OP_RTYPE;
        trap_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end

            ST_FETCH: begin
                // Request is held until acknowledged; never withdrawn
                mem_req_s = 1'b1;
                if (mem_ack) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    pc_src_s     = PC_SRC_PLUS2;
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end

            ST_DECODE: begin
                if (op_class_s == CLS_ILLEGAL) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    next_state_s = ST_TRAP;
`else
                    retire_s     = 1'b1;
                    next_state_s = retire_next_s;
`endif
                end else begin
                    next_state_s = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (op_class_s)
                    CLS_RTYPE: begin
                        alu_src_s    = 1'b0;
                        alu_op_s     = ALU_OP_RTYPE;
                        next_state_s = ST_WB;
                    end
                    CLS_LD, CLS_ST: begin
                        alu_src_s    = 1'b1;
                        alu_op_s     = ALU_OP_ADDR;
                        next_state_s = ST_MEM;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        alu_op_s     = ALU_OP_CMP;
                        pc_src_s     = PC_SRC_BRANCH;
                        pc_write_s   = branch_taken(op_class_s, zero_flag);
                        retire_s     = 1'b1;
                        next_state_s = retire_next_s;
                    end
                    CLS_JMP: begin
                        pc_write_s   = 1'b1;
                        pc_src_s     = PC_SRC_JUMP;
                        retire_s     = 1'b1;
                        next_state_s = retire_next_s;
                    end
                    default: begin
                        // Illegal opcodes never reach EXEC; retire defensively
                        retire_s     = 1'b1;
                        next_state_s = retire_next_s;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req_s = 1'b1;
                mem_we_s  = (op_class_s == CLS_ST);
                if (mem_ack) begin
                    if (op_class_s == CLS_ST) begin
                        retire_s     = 1'b1;
                        next_state_s = retire_next_s;
                    end else begin
                        next_state_s = ST_WB;
                    end
                end else begin
                    next_state_s = ST_MEM;
                end
            end

            ST_WB: begin
                reg_write_s = 1'b1;
                if (op_class_s == CLS_LD) begin
                    mem_to_reg_s = 1'b1;
                    reg_dst_s    = 1'b0;
                end else begin
                    mem_to_reg_s = 1'b0;
                    reg_dst_s    = 1'b1;
                end
                retire_s     = 1'b1;
                next_state_s = retire_next_s;
            end

            ST_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                // Sticky until reset
                trap_s       = 1'b1;
                next_state_s = ST_TRAP;
`else
                next_state_s = ST_IDLE;
`endif
            end

            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output stage: all strobes forced low while reset is asserted
    always_comb begin
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            alu_src    = 1'b0;
            mem_to_reg = 1'b0;
            alu_op     = 2'b00;
            trap       = 1'b0;
        end else begin
            mem_req    = mem_req_s;
            mem_we     = mem_we_s;
            ir_write   = ir_write_s;
            pc_write   = pc_write_s;
            pc_src     = pc_src_s;
            reg_write  = reg_write_s;
            reg_dst    = reg_dst_s;
            alu_src    = alu_src_s;
            mem_to_reg = mem_to_reg_s;
            alu_op     = alu_op_s;
            trap       = trap_s;
        end
    end

    assign state       = state_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer (CNT_W=4).
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic       zero_flag;
    logic       mem_ack;
    logic       mem_req, mem_we, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, alu_src, mem_to_reg;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic [3:0] instr_count;
    logic       trap;

    int n_err    = 0;
    int n_checks = 0;

    // per-instruction measurements
    int         m_cycles, m_rw, m_pw, m_we;
    logic [1:0] m_aop, m_psrc;
    logic       m_asrc, m_dst, m_m2r, m_ok;

    logic [3:0] exp_cnt;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic       zf;
        int         cyc;
        int         rw;
        int         pw;
        int         we;
        logic [1:0] aop;
        logic       asrc;
        logic [1:0] psrc;
        logic       dst;
        logic       m2r;
    } vec_t;

    vec_t tbl[10];

    instr_sequencer #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .zero_flag(zero_flag), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .state(state), .instr_count(instr_count),
        .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Run one instruction starting in FETCH; acks after fw / mw wait cycles.
    task automatic exec_instr(input logic [3:0] op, input logic z, input int fw,
                              input int mw, input logic run_v);
        int         fcnt;
        int         mcnt;
        logic [2:0] prev;
        bit         done;
        fcnt = 0; mcnt = 0; done = 0;
        m_cycles = 0; m_rw = 0; m_pw = 0; m_we = 0;
        m_aop = 2'b00; m_psrc = 2'b00; m_asrc = 1'b0; m_dst = 1'b0; m_m2r = 1'b0;
        opcode = op;
        zero_flag = z;
        while (!done && m_cycles < 60) begin
            @(negedge clk);
            run = run_v;
            if (state == ST_FETCH) begin
                mem_ack = (fcnt >= fw);
                fcnt++;
            end else if (state == ST_MEM) begin
                mem_ack = (mcnt >= mw);
                mcnt++;
            end else begin
                mem_ack = 1'b0;
            end
            #1;
            prev = state;
            if (reg_write) begin m_rw++; m_dst = reg_dst; m_m2r = mem_to_reg; end
            if (pc_write) m_pw++;
            if (mem_req && mem_we) m_we++;
            if (state == ST_EXEC) begin
                m_aop = alu_op; m_asrc = alu_src; m_psrc = pc_src;
            end
            @(posedge clk); #1;
            m_cycles++;
            if (prev != ST_FETCH &&
                (state == ST_FETCH || state == ST_IDLE || state == ST_TRAP))
                done = 1;
        end
        mem_ack = 1'b0;
        m_ok = done;
    endtask

    initial begin
        //            name     op       zf    cyc rw pw we aop    asrc  psrc   dst   m2r
        tbl[0] = '{"add",   4'b0010, 1'b0, 4, 1, 1, 0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[1] = '{"rt9",   4'b1001, 1'b1, 4, 1, 1, 0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[2] = '{"ld",    4'b0000, 1'b0, 5, 1, 1, 0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b1};
        tbl[3] = '{"st",    4'b0001, 1'b0, 4, 0, 1, 1, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[4] = '{"beq_z1",4'b1011, 1'b1, 3, 0, 2, 0, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[5] = '{"beq_z0",4'b1011, 1'b0, 3, 0, 1, 0, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[6] = '{"bne_z1",4'b1100, 1'b1, 3, 0, 1, 0, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[7] = '{"bne_z0",4'b1100, 1'b0, 3, 0, 2, 0, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[8] = '{"jmp",   4'b1101, 1'b0, 3, 0, 2, 0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[9] = '{"rt5",   4'b0101, 1'b0, 4, 1, 1, 0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};

        // Reset, with run and a stray ack asserted
        rst = 1'b1; run = 1'b1; opcode = 4'b0000; zero_flag = 1'b0; mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_trap", trap, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc_write", pc_write, 0);

        // IDLE ignores ack while run=0
        @(negedge clk); rst = 1'b0; run = 1'b0; mem_ack = 1'b1;
        #1;
        chk("idle_no_req", mem_req, 0);
        @(posedge clk); #1;
        chk("idle_hold", state, ST_IDLE);
        @(negedge clk); run = 1'b1; mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("idle_to_fetch", state, ST_FETCH);

        // Zero-wait table
        exp_cnt = 4'd0;
        for (int i = 0; i < 10; i++) begin
            exec_instr(tbl[i].op, tbl[i].zf, 0, 0, 1'b1);
            exp_cnt = exp_cnt + 4'd1;
            chk({tbl[i].name, "_done"}, m_ok, 1);
            chk({tbl[i].name, "_cycles"}, m_cycles, tbl[i].cyc);
            chk({tbl[i].name, "_reg_write"}, m_rw, tbl[i].rw);
            chk({tbl[i].name, "_pc_write"}, m_pw, tbl[i].pw);
            chk({tbl[i].name, "_mem_we"}, m_we, tbl[i].we);
            chk({tbl[i].name, "_alu_op"}, m_aop, tbl[i].aop);
            chk({tbl[i].name, "_alu_src"}, m_asrc, tbl[i].asrc);
            chk({tbl[i].name, "_pc_src"}, m_psrc, tbl[i].psrc);
            if (tbl[i].rw > 0) begin
                chk({tbl[i].name, "_reg_dst"}, m_dst, tbl[i].dst);
                chk({tbl[i].name, "_mem_to_reg"}, m_m2r, tbl[i].m2r);
            end
            chk({tbl[i].name, "_count"}, instr_count, exp_cnt);
            chk({tbl[i].name, "_next"}, state, ST_FETCH);
        end

        // LD with 2 fetch waits and 3 data waits
        exec_instr(4'b0000, 1'b0, 2, 3, 1'b1);
        exp_cnt = exp_cnt + 4'd1;
        chk("ldw_cycles", m_cycles, 10);
        chk("ldw_mem_we", m_we, 0);
        chk("ldw_mem_to_reg", m_m2r, 1);
        chk("ldw_count", instr_count, exp_cnt);

        // ST interrupted by reset during MEM wait; late ack afterwards
        opcode = 4'b0001;
        @(negedge clk); mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("str_decode", state, ST_DECODE);
        @(negedge clk); mem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("str_mem", state, ST_MEM);
        @(negedge clk); #1;
        chk("str_mem_req_wait", mem_req, 1);
        chk("str_mem_we_wait", mem_we, 1);
        rst = 1'b1; #1;
        chk("str_req_in_rst", mem_req, 0);
        chk("str_we_in_rst", mem_we, 0);
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; run = 1'b0; mem_ack = 1'b1; #1;
        chk("str_post_state", state, ST_IDLE);
        chk("str_post_req", mem_req, 0);
        chk("str_post_count", instr_count, 0);
        @(posedge clk); #1;
        chk("str_late_ack", state, ST_IDLE);
        chk("str_late_count", instr_count, 0);
        mem_ack = 1'b0;

        // Counter wrap: 15 retirements then one more with run dropped
        @(negedge clk); run = 1'b1;
        @(posedge clk); #1;
        exp_cnt = 4'd0;
        begin
            int all_ok;
            all_ok = 1;
            for (int k = 0; k < 15; k++) begin
                exec_instr(4'b0011, 1'b0, 0, 0, 1'b1);
                if (!m_ok) all_ok = 0;
            end
            chk("wrap_all_done", all_ok, 1);
        end
        chk("wrap_count15", instr_count, 15);
        exec_instr(4'b0011, 1'b0, 0, 0, 1'b0);
        chk("wrap_cycles", m_cycles, 4);
        chk("wrap_count0", instr_count, 0);
        chk("wrap_idle", state, ST_IDLE);
        @(posedge clk); #1;
        chk("wrap_idle_hold", state, ST_IDLE);

        // Illegal opcode 1111
        @(negedge clk); run = 1'b1;
        @(posedge clk); #1;
        exec_instr(4'b1111, 1'b0, 0, 0, 1'b1);
        chk("ill_done", m_ok, 1);
        chk("ill_cycles", m_cycles, 2);
`ifdef ILLEGAL_OP_TRAP_EN
        chk("ill_state", state, ST_TRAP);
        chk("ill_trap", trap, 1);
        chk("ill_count", instr_count, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ill_state_hold", state, ST_TRAP);
        chk("ill_trap_hold", trap, 1);
`else
        chk("ill_state", state, ST_FETCH);
        chk("ill_trap", trap, 0);
        chk("ill_count", instr_count, 1);
`endif

        // Final reset clears everything
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; run = 1'b0; #1;
        chk("fin_state", state, ST_IDLE);
        chk("fin_trap", trap, 0);
        chk("fin_count", instr_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
